// File: rtl/mux2_arb_pkg.sv
// Purpose: shared types and constants for the two-source byte-mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state_t (arbiter FSM encoding), SIDE_X/SIDE_Y (select/priority
// encoding), DEF_WIDTH (default data width).
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_X = 2'b01,
        OWN_Y = 2'b10
    } state_t;

    // Select and priority-pointer encoding: 0 means the X source, 1 means Y.
    localparam logic SIDE_X = 1'b0;
    localparam logic SIDE_Y = 1'b1;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/mux2_reg.sv
// Purpose: WIDTH-bit registered 2:1 mux with load enable (holds when load=0).
// Latency: one clock from a/b/sel to q.
// Backpressure: none; load=0 simply holds the last captured value.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (q clears to 0)
//   load      - capture enable
//   sel       - 0 selects a, 1 selects b
//   a, b      - data sources
//   q         - registered output
module mux2_reg
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= (sel == SIDE_Y) ? b : a;
        end
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Purpose: round-robin arbiter owning a shared 2:1 byte mux, bounded tenure under contention.
// Latency: request to grant one edge; grant to valid data one further edge.
// Backpressure: none downstream; a contending requester waits at most MAX_HOLD grant cycles.
//
// Ports:
//   CLOCK_50      - system clock, rising edge
//   RESET         - asynchronous active-high reset
//   REQ_X, REQ_Y  - requests from the X and Y sources
//   X, Y          - source data
//   GNT_X, GNT_Y  - current owner, decoded from the state register
//   OWNER         - mux select (0 = X, 1 = Y); holds its value while idle
//   M, M_VALID    - registered mux output and its valid flag
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             REQ_X,
    input  logic             REQ_Y,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             GNT_X,
    output logic             GNT_Y,
    output logic             OWNER,
    output logic [WIDTH-1:0] M,
    output logic             M_VALID
);

    localparam int TW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [TW-1:0] TEN_MAX = TW'(MAX_HOLD - 1);

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
            $error("mux2_arbiter: MAX_HOLD must be within 2..256");
        end
    endgenerate

    state_t          state;
    state_t          nxt;
    logic            last;   // side granted most recently; the other side wins ties
    logic [TW-1:0]   ten;    // cycles spent in the current grant, saturating
    logic            owner_q;
    logic            m_valid_q;

    // Next-state decision. Preemption only happens when the other side is
    // actually waiting; a lone owner keeps the mux indefinitely.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (REQ_X && REQ_Y) begin
                    nxt = (last == SIDE_Y) ? OWN_X : OWN_Y;
                end else if (REQ_X) begin
                    nxt = OWN_X;
                end else if (REQ_Y) begin
                    nxt = OWN_Y;
                end
            end
            OWN_X: begin
                if (!REQ_X) begin
                    nxt = REQ_Y ? OWN_Y : IDLE;
                end else if (REQ_Y && ten == TEN_MAX) begin
                    nxt = OWN_Y;
                end
            end
            OWN_Y: begin
                if (!REQ_Y) begin
                    nxt = REQ_X ? OWN_X : IDLE;
                end else if (REQ_X && ten == TEN_MAX) begin
                    nxt = OWN_X;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            last      <= SIDE_Y;   // X wins the first tie after reset
            owner_q   <= SIDE_X;
            ten       <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state     <= nxt;
            // Valid tracks the state that selected the byte captured this edge,
            // so it trails the grant by one cycle and stays high across a handoff.
            m_valid_q <= (state != IDLE);
            if (nxt != IDLE && nxt != state) begin
                // Entry into a grant state (from idle or a direct handoff).
                ten     <= '0;
                last    <= (nxt == OWN_Y) ? SIDE_Y : SIDE_X;
                owner_q <= (nxt == OWN_Y) ? SIDE_Y : SIDE_X;
            end else if (state != IDLE && ten != TEN_MAX) begin
                ten <= ten + 1'b1;
            end
        end
    end

    assign GNT_X   = (state == OWN_X);
    assign GNT_Y   = (state == OWN_Y);
    assign OWNER   = owner_q;
    assign M_VALID = m_valid_q;

    // The data register loads from the source owning the mux during the
    // current cycle, which puts M one cycle behind the grant.
    mux2_reg #(
        .WIDTH (WIDTH)
    ) u_mux_reg (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .load (state != IDLE),
        .sel  (state == OWN_Y),
        .a    (X),
        .b    (Y),
        .q    (M)
    );

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

    logic       clk;
    logic       rst;
    logic       req_x;
    logic       req_y;
    logic [7:0] x;
    logic [7:0] y;
    logic       gnt_x;
    logic       gnt_y;
    logic       owner;
    logic [7:0] m;
    logic       m_valid;

    int n_assert = 0;
    int n_fail   = 0;

    mux2_arbiter #(
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .REQ_X    (req_x),
        .REQ_Y    (req_y),
        .X        (x),
        .Y        (y),
        .GNT_X    (gnt_x),
        .GNT_Y    (gnt_y),
        .OWNER    (owner),
        .M        (m),
        .M_VALID  (m_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_side;
        rst = 1'b1; req_x = 1'b0; req_y = 1'b0; x = 8'h00; y = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_gnt_x",   gnt_x,   1'b0);
        chk("rst_gnt_y",   gnt_y,   1'b0);
        chk("rst_owner",   owner,   1'b0);
        chk("rst_m",       m,       8'h00);
        chk("rst_m_valid", m_valid, 1'b0);
        rst = 1'b0;

        // Single request on X
        req_x = 1'b1; x = 8'hA5;
        tick();
        chk("single_gnt_x",    gnt_x,   1'b1);
        chk("single_gnt_y",    gnt_y,   1'b0);
        chk("single_val_lag",  m_valid, 1'b0);
        tick();
        chk("single_m",        m,       8'hA5);
        chk("single_m_valid",  m_valid, 1'b1);
        chk("single_owner",    owner,   1'b0);
        chk("single_gnt_y2",   gnt_y,   1'b0);
        req_x = 1'b0;
        tick();
        chk("drop_gnt_x",      gnt_x,   1'b0);
        chk("drop_val_lag",    m_valid, 1'b1);
        tick();
        chk("drop_m_valid",    m_valid, 1'b0);
        chk("drop_m_hold",     m,       8'hA5);

        // Tie break from reset: X first, then direct handoff to Y
        rst = 1'b1; #1;
        rst = 1'b0;
        req_x = 1'b1; req_y = 1'b1; x = 8'h11; y = 8'h22;
        tick();
        chk("tie_gnt_x",   gnt_x, 1'b1);
        chk("tie_gnt_y",   gnt_y, 1'b0);
        tick();
        chk("tie_m_x",     m,       8'h11);
        chk("tie_val1",    m_valid, 1'b1);
        req_x = 1'b0;
        tick();
        chk("hand_gnt_y",  gnt_y,   1'b1);
        chk("hand_gnt_x",  gnt_x,   1'b0);
        chk("hand_owner",  owner,   1'b1);
        chk("hand_val",    m_valid, 1'b1);
        chk("hand_m_old",  m,       8'h11);
        tick();
        chk("hand_m_new",  m,       8'h22);
        chk("hand_val2",   m_valid, 1'b1);

        // Contended preemption, MAX_HOLD=4: XXXX YYYY XXXX
        rst = 1'b1; #1;
        rst = 1'b0;
        x = 8'h5A; y = 8'hC3;
        req_x = 1'b1; req_y = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_side = (((i - 1) / 4) % 2) == 1;
            chk($sformatf("pre_gnt_x_%0d", i), gnt_x, !exp_side);
            chk($sformatf("pre_gnt_y_%0d", i), gnt_y, exp_side);
            if (i >= 2) begin
                // M reflects the owner of the previous cycle
                chk($sformatf("pre_m_%0d", i), m,
                    ((((i - 2) / 4) % 2) == 1) ? 8'hC3 : 8'h5A);
                chk($sformatf("pre_val_%0d", i), m_valid, 1'b1);
            end
        end

        // Uncontended hold on Y for 40 cycles
        rst = 1'b1; #1;
        rst = 1'b0;
        req_x = 1'b0; req_y = 1'b1; y = 8'h3C;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk($sformatf("hold_gnt_y_%0d", i), gnt_y, 1'b1);
        end
        chk("hold_ten_sat", dut.ten,  2'd3);
        chk("hold_m",       m,        8'h3C);
        chk("hold_valid",   m_valid,  1'b1);
        chk("hold_owner",   owner,    1'b1);

        // Asynchronous reset mid-grant
        #3;
        rst = 1'b1;
        #1;
        chk("arst_gnt_y",   gnt_y,   1'b0);
        chk("arst_m",       m,       8'h00);
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_owner",   owner,   1'b0);
        req_x = 1'b1; req_y = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        chk("arst_tie_x",   gnt_x, 1'b1);
        chk("arst_tie_y",   gnt_y, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
